// File: rtl/skin_bbox_tracker.sv
// Reduces a per-pixel skin mask to one bounding box per frame, rejecting
// horizontal skin runs shorter than MIN_RUN before they reach the box accumulators.
module skin_bbox_tracker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_RUN   = 4,
  parameter int MIN_COUNT = 64
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic [9:0]  mask_in,
  output logic [9:0]  box_x0,
  output logic [9:0]  box_x1,
  output logic [9:0]  box_y0,
  output logic [9:0]  box_y1,
  output logic [19:0] box_count,
  output logic        box_found,
  output logic        box_done
);

  localparam int              RW       = (MIN_RUN < 1) ? 1 : $clog2(MIN_RUN + 1);
  localparam logic [RW-1:0]   RUN_MAX  = RW'(MIN_RUN);
  localparam logic [9:0]      X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]      RUN_SPAN = 10'(MIN_RUN - 1);
  localparam logic [19:0]     CNT_MAX  = 20'hF_FFFF;
  localparam logic [19:0]     CNT_MIN  = 20'(MIN_COUNT);
  localparam logic [20:0]     ADD_RUN  = 21'(MIN_RUN);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [RW-1:0] run_q, run_d;
  logic [9:0]    min_x_q, min_x_d, max_x_q, max_x_d;
  logic [9:0]    min_y_q, min_y_d, max_y_q, max_y_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          report_q, report_d;
  logic [9:0]    box_x0_q, box_x0_d, box_x1_q, box_x1_d;
  logic [9:0]    box_y0_q, box_y0_d, box_y1_q, box_y1_d;
  logic [19:0]   box_count_q, box_count_d;
  logic          box_found_q, box_found_d;
  logic          box_done_q, box_done_d;

  logic          take_s, qual_grp_s, qual_one_s;
  logic [9:0]    px_x_s, px_y_s, grp_x0_s;
  logic [RW-1:0] run_b_s, run_n_s;
  logic [9:0]    min_x_b_s, max_x_b_s, min_y_b_s, max_y_b_s;
  logic [19:0]   cnt_b_s;
  logic [20:0]   add_s, cnt_sum_s;
  logic          unused_mask_s;

  assign unused_mask_s = ^mask_in[8:0];

  // Pixel processing, frame sequencing and report loading.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    run_d       = run_q;
    min_x_d     = min_x_q;
    max_x_d     = max_x_q;
    min_y_d     = min_y_q;
    max_y_d     = max_y_q;
    cnt_d       = cnt_q;
    report_d    = 1'b0;
    box_x0_d    = box_x0_q;
    box_x1_d    = box_x1_q;
    box_y0_d    = box_y0_q;
    box_y1_d    = box_y1_q;
    box_count_d = box_count_q;
    box_found_d = box_found_q;
    box_done_d  = 1'b0;
    qual_grp_s  = 1'b0;
    qual_one_s  = 1'b0;
    add_s       = 21'd0;
    run_n_s     = {RW{1'b0}};

    take_s    = pix_valid & (sof | (state_q == SCAN));
    // sof restarts at (0,0) on cleared accumulators, whatever the current state.
    px_x_s    = sof ? 10'd0 : x_q;
    px_y_s    = sof ? 10'd0 : y_q;
    run_b_s   = sof ? {RW{1'b0}} : run_q;
    min_x_b_s = sof ? 10'h3FF : min_x_q;
    max_x_b_s = sof ? 10'd0 : max_x_q;
    min_y_b_s = sof ? 10'h3FF : min_y_q;
    max_y_b_s = sof ? 10'd0 : max_y_q;
    cnt_b_s   = sof ? 20'd0 : cnt_q;
    grp_x0_s  = px_x_s - RUN_SPAN;

    if (mask_in[9]) begin
      if (run_b_s == RUN_MAX) begin
        run_n_s    = run_b_s;
        qual_one_s = 1'b1;
        add_s      = 21'd1;
      end else begin
        run_n_s = run_b_s + RW'(1);
        if (run_n_s == RUN_MAX) begin
          qual_grp_s = 1'b1;
          add_s      = ADD_RUN;
        end else begin
          qual_grp_s = 1'b0;
        end
      end
    end else begin
      run_n_s = {RW{1'b0}};
    end
    cnt_sum_s = {1'b0, cnt_b_s} + add_s;

    if (take_s) begin
      state_d = SCAN;
      run_d   = run_n_s;
      cnt_d   = cnt_sum_s[20] ? CNT_MAX : cnt_sum_s[19:0];
      min_x_d = (qual_grp_s && (grp_x0_s < min_x_b_s)) ? grp_x0_s : min_x_b_s;
      if ((qual_grp_s || qual_one_s) && (px_x_s > max_x_b_s)) begin
        max_x_d = px_x_s;
      end else begin
        max_x_d = max_x_b_s;
      end
      if ((qual_grp_s || qual_one_s) && (px_y_s < min_y_b_s)) begin
        min_y_d = px_y_s;
      end else begin
        min_y_d = min_y_b_s;
      end
      if ((qual_grp_s || qual_one_s) && (px_y_s > max_y_b_s)) begin
        max_y_d = px_y_s;
      end else begin
        max_y_d = max_y_b_s;
      end
      if (px_x_s == X_LAST) begin
        x_d   = 10'd0;
        run_d = {RW{1'b0}};
        if (px_y_s == Y_LAST) begin
          y_d      = 10'd0;
          report_d = 1'b1;
          state_d  = IDLE;
        end else begin
          y_d = px_y_s + 10'd1;
        end
      end else begin
        x_d = px_x_s + 10'd1;
        y_d = px_y_s;
      end
    end else begin
      state_d = state_q;
    end

    // Report reads the accumulators one edge after the final pixel, so a
    // back-to-back sof clearing them on that same edge cannot corrupt it.
    if (report_q) begin
      box_x0_d    = (cnt_q == 20'd0) ? 10'd0 : min_x_q;
      box_x1_d    = (cnt_q == 20'd0) ? 10'd0 : max_x_q;
      box_y0_d    = (cnt_q == 20'd0) ? 10'd0 : min_y_q;
      box_y1_d    = (cnt_q == 20'd0) ? 10'd0 : max_y_q;
      box_count_d = cnt_q;
      box_found_d = (cnt_q >= CNT_MIN);
      box_done_d  = 1'b1;
    end else begin
      box_done_d = 1'b0;
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      run_q       <= {RW{1'b0}};
      min_x_q     <= 10'd0;
      max_x_q     <= 10'd0;
      min_y_q     <= 10'd0;
      max_y_q     <= 10'd0;
      cnt_q       <= 20'd0;
      report_q    <= 1'b0;
      box_x0_q    <= 10'd0;
      box_x1_q    <= 10'd0;
      box_y0_q    <= 10'd0;
      box_y1_q    <= 10'd0;
      box_count_q <= 20'd0;
      box_found_q <= 1'b0;
      box_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      run_q       <= run_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      cnt_q       <= cnt_d;
      report_q    <= report_d;
      box_x0_q    <= box_x0_d;
      box_x1_q    <= box_x1_d;
      box_y0_q    <= box_y0_d;
      box_y1_q    <= box_y1_d;
      box_count_q <= box_count_d;
      box_found_q <= box_found_d;
      box_done_q  <= box_done_d;
    end
  end

  assign box_x0    = box_x0_q;
  assign box_x1    = box_x1_q;
  assign box_y0    = box_y0_q;
  assign box_y1    = box_y1_q;
  assign box_count = box_count_q;
  assign box_found = box_found_q;
  assign box_done  = box_done_q;

endmodule

// File: tb/tb_skin_bbox_tracker.sv
// Directed bench for skin_bbox_tracker on an 8x4 frame with MIN_RUN=2, MIN_COUNT=3.
module tb_skin_bbox_tracker;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [9:0]  mask_in = 10'd0;
  logic [9:0]  box_x0, box_x1, box_y0, box_y1;
  logic [19:0] box_count;
  logic        box_found, box_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rep_q[$];
  int d0;

  skin_bbox_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_RUN(2), .MIN_COUNT(3)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .pix_valid(pix_valid), .sof(sof),
    .mask_in(mask_in), .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0),
    .box_y1(box_y1), .box_count(box_count), .box_found(box_found), .box_done(box_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Count report strobes and remember each reported count.
  always @(negedge CLOCK_50) begin
    if (box_done) begin
      done_cnt++;
      rep_q.push_back(int'(box_count));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_box(input string tag, input int x0, input int x1, input int y0,
                           input int y1, input int cnt, input int found);
    chk({tag, ".x0"}, 32'(box_x0), x0);
    chk({tag, ".x1"}, 32'(box_x1), x1);
    chk({tag, ".y0"}, 32'(box_y0), y0);
    chk({tag, ".y1"}, 32'(box_y1), y1);
    chk({tag, ".count"}, 32'(box_count), cnt);
    chk({tag, ".found"}, 32'(box_found), found);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      pix_valid = 1'b0;
      sof = 1'b0;
      mask_in = 10'd0;
    end
  endtask

  // Pixel p sits at x = p % 8, y = p / 8; skin where map[p] is set.
  task automatic run_frame(input logic [31:0] map, input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        @(negedge CLOCK_50);
        pix_valid = 1'b0;
        sof = 1'($urandom);
        mask_in = 10'($urandom);
      end
      @(negedge CLOCK_50);
      pix_valid = 1'b1;
      sof = (p == 0);
      mask_in = map[p] ? 10'h3FF : 10'h000;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_box("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.done", 32'(box_done), 0);
    reset_n = 1'b1;

    // All non-skin, continuous pixels: check exact done timing.
    d0 = done_cnt;
    run_frame(32'h0000_0000, 32, 1'b0);
    @(negedge CLOCK_50);
    pix_valid = 1'b0; sof = 1'b0;
    chk("t1.done_early", 32'(box_done), 0);
    @(negedge CLOCK_50);
    chk("t1.done_pulse", 32'(box_done), 1);
    @(negedge CLOCK_50);
    chk("t1.done_width", 32'(box_done), 0);
    check_box("t1", 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t1.ndone", 32'(done_cnt - d0), 1);

    // Two-line blob with random gaps.
    d0 = done_cnt;
    run_frame(32'h0018_3C00, 32, 1'b1);
    idle(4);
    check_box("t2", 2, 5, 1, 2, 6, 1);
    chk("t2.ndone", 32'(done_cnt - d0), 1);

    // Isolated pixels never qualify.
    d0 = done_cnt;
    run_frame(32'h8010_0002, 32, 1'b1);
    idle(4);
    check_box("t3", 0, 0, 0, 0, 0, 0);
    chk("t3.ndone", 32'(done_cnt - d0), 1);

    // Run ending a line does not continue on the next.
    d0 = done_cnt;
    run_frame(32'h0001_C000, 32, 1'b1);
    idle(4);
    check_box("t4", 6, 7, 1, 1, 2, 0);
    chk("t4.ndone", 32'(done_cnt - d0), 1);

    // Frame A aborted after 13 pixels by frame B's sof.
    d0 = done_cnt;
    run_frame(32'hFFFF_FFFF, 13, 1'b1);
    idle(1);
    check_box("t5a", 6, 7, 1, 1, 2, 0);
    run_frame(32'h0F00_0000, 32, 1'b1);
    idle(4);
    check_box("t5b", 0, 3, 3, 3, 4, 1);
    chk("t5.ndone", 32'(done_cnt - d0), 1);

    // Asynchronous reset mid-frame, then sof-less pixels are ignored.
    run_frame(32'hFFFF_FFFF, 10, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_box("t6rst", 0, 0, 0, 0, 0, 0);
    chk("t6rst.done", 32'(box_done), 0);
    idle(1);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (40) begin
      @(negedge CLOCK_50);
      pix_valid = 1'b1; sof = 1'b0; mask_in = 10'h3FF;
    end
    idle(4);
    check_box("t6nosof", 0, 0, 0, 0, 0, 0);
    chk("t6nosof.ndone", 32'(done_cnt - d0), 0);

    // Full frame, then a sof on the very next edge after its last pixel.
    d0 = done_cnt;
    run_frame(32'h0000_00FF, 32, 1'b0);
    run_frame(32'h8010_0002, 32, 1'b0);
    idle(4);
    chk("t7.ndone", 32'(done_cnt - d0), 2);
    if (rep_q.size() >= 2) begin
      chk("t7.rep_first", 32'(rep_q[rep_q.size() - 2]), 8);
      chk("t7.rep_second", 32'(rep_q[rep_q.size() - 1]), 0);
    end else begin
      chk("t7.rep_size", 32'(rep_q.size()), 2);
    end
    check_box("t7", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skin_bbox_tracker.md
# skin_bbox_tracker

Consumes the per-pixel skin/non-skin mask produced by the skin classification stage and reduces each frame to one bounding box around the skin region. The box is the face candidate. A horizontal run-length filter rejects isolated skin pixels before they reach the box accumulators. Results are latched once per frame with a one-cycle done strobe for the downstream overlay and tracking logic.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_RUN, 4, consecutive skin pixels in one line required before any of them counts (≥1)
- MIN_COUNT, 64, qualified-pixel count at or above which box_found asserts

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  mask_in/sof carry a pixel this cycle
- sof  in  1  start of frame; meaningful only with pix_valid; marks pixel (0,0)
- mask_in  in  10  classifier output; skin = mask_in[9] (classifier drives all-ones or all-zeros)
- box_x0, box_x1  out  10  leftmost / rightmost qualified column
- box_y0, box_y1  out  10  top / bottom qualified line
- box_count  out  20  number of qualified pixels in the frame
- box_found  out  1  box_count ≥ MIN_COUNT
- box_done  out  1  one-cycle pulse when the outputs above are updated

## Operation
- States: IDLE and SCAN. Reset enters IDLE.
- IDLE: pixels without sof are ignored. A pixel with pix_valid&sof moves the block to SCAN and is processed as (x=0, y=0). Accumulators are cleared on that pixel: min_x=min_y=all-ones, max_x=max_y=0, count=0, run=0.
- SCAN: each pix_valid pixel is processed at (x, y). After the pixel, x increments. At x==H_ACTIVE-1, x wraps to 0 and y increments.
- Cycles with pix_valid=0 change nothing.
- Run filter: the run counter saturates at MIN_RUN.
  - A skin pixel increments run.
  - A non-skin pixel clears run.
  - The counter is also cleared after the last pixel of every line, so runs never span lines.
- Qualification:
  - When run reaches MIN_RUN at column x, pixels x-MIN_RUN+1..x qualify. count += MIN_RUN; min_x = min(min_x, x-MIN_RUN+1); max_x = max(max_x, x).
  - A skin pixel arriving while run is already saturated qualifies alone: count += 1; max_x = max(max_x, x).
  - Any qualification updates min_y and max_y with y.
- count saturates at 2^20-1.
- Frame end: the pixel at x=H_ACTIVE-1, y=V_ACTIVE-1 is processed, then the block reports and returns to IDLE.
  - box_x0/x1/y0/y1 take min_x/max_x/min_y/max_y.
  - If count==0, all four coordinates are 0.
  - box_count takes count.
  - box_found = (count ≥ MIN_COUNT).
  - box_done pulses.
- sof arriving with pix_valid in SCAN aborts the current frame: no report is made and outputs keep their previous values. That pixel starts a new frame at (0,0) with cleared accumulators.
- Outputs hold between reports.
- Reset: asynchronous. All outputs go to 0 (box_done=0, box_found=0). The state goes to IDLE and x, y, run and all accumulators are cleared. A frame in progress is discarded.

## Timing
- Accumulators update on the edge that samples the pixel (edge N).
- For the last pixel of a frame: outputs are registered at edge N+1 and box_done is high for the single cycle following edge N+1.
- A sof may arrive at edge N+1 or later. A sof at edge N+1 starts the next frame normally and does not disturb the report.
- No backpressure: a pixel is accepted every cycle pix_valid is high. Throughput is one pixel per clock.
- reset_n asserted mid-frame forces all outputs to 0 without waiting for a clock edge.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4, MIN_RUN=2, MIN_COUNT=3 unless stated otherwise.
- All non-skin frame, pix_valid continuously high -> one box_done pulse one cycle after the 32nd pixel; box_count=0, box_found=0, all coordinates 0.
- Skin at line 1 x=2..5 and line 2 x=3..4, with random pix_valid gaps -> box_x0=2, x1=5, y0=1, y1=2, box_count=6, box_found=1; box_done fires exactly once.
- Isolated single skin pixels at (1,0), (4,2), (7,3) -> box_count=0, box_found=0, coordinates 0.
- Skin at line 1 x=6..7 continuing at line 2 x=0 -> run not carried across the line; box_count=2, box_x0=6, x1=7, y0=y1=1, box_found=0.
- Second sof after 13 pixels of frame A -> no box_done for A, outputs unchanged; frame B (skin at line 3 x=0..3) reports x0=0, x1=3, y0=y1=3, count=4, found=1.
- reset_n pulsed low mid-frame after a prior report -> all outputs 0 immediately; pixels without sof are ignored; the next full frame reports correctly.
